// File: rtl/present_iter_core.sv
// present_iter_core
// Round-iterative PRESENT block cipher, 64-bit block, 80- or 128-bit key,
// one round per clock.
//
// Optional feature macro: PRESENT_DECRYPT_EN
//   defined   : decryption (PREROLL state, inverse layers, inverse key
//               schedule) is compiled in; the decrypt input selects the mode.
//   undefined : the decrypt input is ignored and every request encrypts.
//
// Handshake: a request is taken on a rising clk edge where start=1 and
// busy=0 (the core is in IDLE). data_in, key and decrypt are sampled on that
// edge only. busy is high from the next cycle until the result arrives.
// done is a one-cycle pulse with data_out valid in the same cycle, and
// data_out holds until the following done. Because busy is already low in
// the done cycle, a start held high then is taken on the next edge. A start
// seen while busy=1 is dropped, not queued. Reset wins over start.
//
// dbg_state exposes the FSM state: 0=IDLE, 1=PREROLL, 2=ROUND, 3=FINAL.

module present_iter_core #(
  parameter int KEY_WIDTH = 80
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 decrypt,
  input  logic [63:0]          data_in,
  input  logic [KEY_WIDTH-1:0] key,
  output logic                 busy,
  output logic                 done,
  output logic [63:0]          data_out,
  output logic [1:0]           dbg_state
);

  // Only the two standard PRESENT key lengths have a defined key schedule.
  if (KEY_WIDTH != 80 && KEY_WIDTH != 128) begin : g_bad_key_width
    $error("present_iter_core: KEY_WIDTH must be 80 or 128");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PREROLL = 2'd1,
    ROUND   = 2'd2,
    FINAL   = 2'd3
  } state_t;

  // ---------------------------------------------------------------------
  // S-boxes
  // ---------------------------------------------------------------------
  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hc;
      4'h1: y = 4'h5;
      4'h2: y = 4'h6;
      4'h3: y = 4'hb;
      4'h4: y = 4'h9;
      4'h5: y = 4'h0;
      4'h6: y = 4'ha;
      4'h7: y = 4'hd;
      4'h8: y = 4'h3;
      4'h9: y = 4'he;
      4'ha: y = 4'hf;
      4'hb: y = 4'h8;
      4'hc: y = 4'h4;
      4'hd: y = 4'h7;
      4'he: y = 4'h1;
      default: y = 4'h2;
    endcase
    return y;
  endfunction

`ifdef PRESENT_DECRYPT_EN
  function automatic logic [3:0] sbox_inv(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'h5;
      4'h1: y = 4'he;
      4'h2: y = 4'hf;
      4'h3: y = 4'h8;
      4'h4: y = 4'hc;
      4'h5: y = 4'h1;
      4'h6: y = 4'h2;
      4'h7: y = 4'hd;
      4'h8: y = 4'hb;
      4'h9: y = 4'h4;
      4'ha: y = 4'h6;
      4'hb: y = 4'h3;
      4'hc: y = 4'h0;
      4'hd: y = 4'h7;
      4'he: y = 4'h9;
      default: y = 4'ha;
    endcase
    return y;
  endfunction
`endif

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  state_t               st_q, st_d;
  logic [63:0]          blk_q, blk_d;     // cipher state
  logic [KEY_WIDTH-1:0] key_q, key_d;     // key register
  logic [4:0]           rc_q, rc_d;       // round counter
  logic                 mode_q, mode_d;   // 1 = decrypting
  logic                 busy_d, done_d;
  logic [63:0]          dout_d;
  logic                 req_dec;

  assign dbg_state = st_q;

`ifdef PRESENT_DECRYPT_EN
  assign req_dec = decrypt;
`else
  // Port kept for a stable interface; it has no effect in this build.
  logic unused_decrypt;
  assign unused_decrypt = decrypt;
  assign req_dec        = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // Round datapath
  // ---------------------------------------------------------------------
  logic [63:0] rk;        // current round key
  logic [63:0] x;         // state after key addition
  logic [63:0] s_enc;     // after forward S-layer
  logic [63:0] rnd_enc;   // after forward P-layer

  assign rk = key_q[KEY_WIDTH-1 -: 64];
  assign x  = blk_q ^ rk;

  for (genvar n = 0; n < 16; n++) begin : g_sbox
    assign s_enc[4*n +: 4] = sbox(x[4*n +: 4]);
  end

  // P-layer: bit i moves to bit 16*i mod 63; bit 63 stays in place.
  for (genvar i = 0; i < 63; i++) begin : g_perm
    assign rnd_enc[(i*16)%63] = s_enc[i];
  end
  assign rnd_enc[63] = s_enc[63];

`ifdef PRESENT_DECRYPT_EN
  logic [63:0] p_inv;     // after inverse P-layer
  logic [63:0] rnd_dec;   // after inverse S-layer

  // Inverse P-layer: bit i is fetched from bit 16*i mod 63.
  for (genvar i = 0; i < 63; i++) begin : g_perm_inv
    assign p_inv[i] = x[(i*16)%63];
  end
  assign p_inv[63] = x[63];

  for (genvar n = 0; n < 16; n++) begin : g_sbox_inv
    assign rnd_dec[4*n +: 4] = sbox_inv(p_inv[4*n +: 4]);
  end
`endif

  // ---------------------------------------------------------------------
  // Key schedule
  // ---------------------------------------------------------------------
  logic [KEY_WIDTH-1:0] key_fwd;
`ifdef PRESENT_DECRYPT_EN
  logic [KEY_WIDTH-1:0] key_inv;
`endif

  if (KEY_WIDTH == 128) begin : g_k128
    // Forward update: rotate left 61, S-box the top two nibbles, counter into [66:62].
    always_comb begin
      key_fwd          = {key_q[66:0], key_q[127:67]};
      key_fwd[127:124] = sbox(key_fwd[127:124]);
      key_fwd[123:120] = sbox(key_fwd[123:120]);
      key_fwd[66:62]   = key_fwd[66:62] ^ rc_q;
    end
`ifdef PRESENT_DECRYPT_EN
    logic [127:0] t;
    // Inverse update: undo counter, undo S-boxes, rotate right 61.
    always_comb begin
      t          = key_q;
      t[66:62]   = t[66:62] ^ rc_q;
      t[127:124] = sbox_inv(t[127:124]);
      t[123:120] = sbox_inv(t[123:120]);
      key_inv    = {t[60:0], t[127:61]};
    end
`endif
  end else begin : g_k80
    // Forward update: rotate left 61, S-box the top nibble, counter into [19:15].
    always_comb begin
      key_fwd        = {key_q[18:0], key_q[79:19]};
      key_fwd[79:76] = sbox(key_fwd[79:76]);
      key_fwd[19:15] = key_fwd[19:15] ^ rc_q;
    end
`ifdef PRESENT_DECRYPT_EN
    logic [79:0] t;
    // Inverse update: undo counter, undo S-box, rotate right 61.
    always_comb begin
      t        = key_q;
      t[19:15] = t[19:15] ^ rc_q;
      t[79:76] = sbox_inv(t[79:76]);
      key_inv  = {t[60:0], t[79:61]};
    end
`endif
  end

  // ---------------------------------------------------------------------
  // Control
  // ---------------------------------------------------------------------
  // Next-state and next-register values; everything holds unless a state acts.
  always_comb begin
    st_d   = st_q;
    blk_d  = blk_q;
    key_d  = key_q;
    rc_d   = rc_q;
    mode_d = mode_q;
    busy_d = busy_q_w();
    done_d = 1'b0;
    dout_d = data_out;
    case (st_q)
      IDLE: begin
        if (start) begin
          blk_d  = data_in;
          key_d  = key;
          rc_d   = 5'd1;
          busy_d = 1'b1;
          mode_d = req_dec;
          st_d   = req_dec ? PREROLL : ROUND;
        end
      end
      PREROLL: begin
`ifdef PRESENT_DECRYPT_EN
        // Run the forward schedule to K32; rc stays at 31 for the first
        // inverse round.
        key_d = key_fwd;
        if (rc_q == 5'd31) st_d = ROUND;
        else               rc_d = rc_q + 5'd1;
`else
        st_d = IDLE;
`endif
      end
      ROUND: begin
`ifdef PRESENT_DECRYPT_EN
        if (mode_q) begin
          blk_d = rnd_dec;
          key_d = key_inv;
          if (rc_q == 5'd1) st_d = FINAL;
          else              rc_d = rc_q - 5'd1;
        end else
`endif
        begin
          blk_d = rnd_enc;
          key_d = key_fwd;
          if (rc_q == 5'd31) st_d = FINAL;
          else               rc_d = rc_q + 5'd1;
        end
      end
      FINAL: begin
        // Last whitening key: K32 when encrypting, K1 when decrypting.
        dout_d = x;
        done_d = 1'b1;
        busy_d = 1'b0;
        st_d   = IDLE;
      end
      default: st_d = IDLE;
    endcase
  end

  function automatic logic busy_q_w();
    return busy;
  endfunction

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q     <= IDLE;
      blk_q    <= '0;
      key_q    <= '0;
      rc_q     <= '0;
      mode_q   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      data_out <= '0;
    end else begin
      st_q     <= st_d;
      blk_q    <= blk_d;
      key_q    <= key_d;
      rc_q     <= rc_d;
      mode_q   <= mode_d;
      busy     <= busy_d;
      done     <= done_d;
      data_out <= dout_d;
    end
  end

endmodule

// File: tb/tb_present_iter_core.sv
// tb_present_iter_core
// Drives an 80-bit-key and a 128-bit-key instance with directed vectors.
// Each request pushes its expected result and expected done cycle; a
// monitor per instance pops and compares whenever done is seen.

module tb_present_iter_core;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        reset, start, decrypt;
  logic [63:0] data_in;
  logic [79:0] key;
  logic        busy, done;
  logic [63:0] data_out;
  logic [1:0]  dbg_state;

  logic         start_w, decrypt_w;
  logic [63:0]  data_in_w;
  logic [127:0] key_w;
  logic         busy_w, done_w;
  logic [63:0]  data_out_w;
  logic [1:0]   dbg_state_w;

  present_iter_core #(.KEY_WIDTH(80)) dut (
    .clk(clk), .reset(reset), .start(start), .decrypt(decrypt),
    .data_in(data_in), .key(key), .busy(busy), .done(done),
    .data_out(data_out), .dbg_state(dbg_state)
  );

  present_iter_core #(.KEY_WIDTH(128)) dut_w (
    .clk(clk), .reset(reset), .start(start_w), .decrypt(decrypt_w),
    .data_in(data_in_w), .key(key_w), .busy(busy_w), .done(done_w),
    .data_out(data_out_w), .dbg_state(dbg_state_w)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [63:0] exp_q[$];
  int          when_q[$];
  logic [63:0] exp_w_q[$];
  int          when_w_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor for the 80-bit instance.
  always @(negedge clk) begin : mon80
    logic [63:0] e;
    int          w;
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done80: done=1 at cycle %0d, expected no done", cyc);
      end else begin
        e = exp_q.pop_front();
        w = when_q.pop_front();
        check("data_out80", data_out, e);
        check("done_cycle80", 64'(cyc), 64'(w));
        check("busy_at_done80", {63'd0, busy}, 64'd0);
      end
    end
  end

  // Monitor for the 128-bit instance.
  always @(negedge clk) begin : mon128
    logic [63:0] e;
    int          w;
    if (done_w === 1'b1) begin
      if (exp_w_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done128: done=1 at cycle %0d, expected no done", cyc);
      end else begin
        e = exp_w_q.pop_front();
        w = when_w_q.pop_front();
        check("data_out128", data_out_w, e);
        check("done_cycle128", 64'(cyc), 64'(w));
      end
    end
  end

  // ---------------- reference for round-trip vectors ----------------
  function automatic logic [3:0] sbox_m(input logic [3:0] v);
    logic [63:0] tbl;
    tbl = 64'h21748fe3da09b65c;
    return 4'(tbl >> (4 * v));
  endfunction

  function automatic logic [63:0] model_enc80(input logic [63:0] pt, input logic [79:0] k);
    logic [63:0] s, t, p;
    logic [79:0] kk;
    int j;
    s  = pt;
    kk = k;
    for (int r = 1; r <= 31; r++) begin
      s = s ^ kk[79:16];
      t = '0;
      for (int n = 0; n < 16; n++) begin
        t = {sbox_m(s[3:0]), t[63:4]};
        s = s >> 4;
      end
      p = '0;
      for (int i = 0; i < 64; i++) begin
        j = (i == 63) ? 63 : (i * 16) % 63;
        p = p | (64'(t[0]) << j);
        t = t >> 1;
      end
      s = p;
      kk = {kk[18:0], kk[79:19]};
      kk[79:76] = sbox_m(kk[79:76]);
      kk[19:15] = kk[19:15] ^ 5'(r);
    end
    return s ^ kk[79:16];
  endfunction

  // ---------------- drivers ----------------
  task automatic issue(input logic [63:0] d, input logic [79:0] k, input logic dc,
                       input logic [63:0] e, input int lat, output int w);
    int guard;
    logic [95:0] r;
    guard = 0;
    @(negedge clk);
    while (busy && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    start = 1'b1; decrypt = dc; data_in = d; key = k;
    w = cyc + lat + 1;
    exp_q.push_back(e);
    when_q.push_back(w);
    @(negedge clk);
    r = {$urandom(), $urandom(), $urandom()};
    start = 1'b0; decrypt = ~dc; data_in = r[63:0]; key = r[95:16];
    check("busy_after_start80", {63'd0, busy}, 64'd1);
  endtask

  task automatic issue_w(input logic [63:0] d, input logic [127:0] k, input logic dc,
                         input logic [63:0] e, input int lat);
    int guard;
    logic [127:0] r;
    guard = 0;
    @(negedge clk);
    while (busy_w && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    start_w = 1'b1; decrypt_w = dc; data_in_w = d; key_w = k;
    exp_w_q.push_back(e);
    when_w_q.push_back(cyc + lat + 1);
    @(negedge clk);
    r = {$urandom(), $urandom(), $urandom(), $urandom()};
    start_w = 1'b0; decrypt_w = ~dc; data_in_w = r[63:0]; key_w = r;
    check("busy_after_start128", {63'd0, busy_w}, 64'd1);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || exp_w_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0 || exp_w_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL timeout: %0d results outstanding, expected 0", exp_q.size() + exp_w_q.size());
      exp_q.delete(); when_q.delete(); exp_w_q.delete(); when_w_q.delete();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    int w;
    int wa;
    int guard;
    logic [63:0] rt_pt, rt_ct;
    logic [79:0] rt_key;

    reset = 1'b1; start = 1'b0; decrypt = 1'b0; data_in = '0; key = '0;
    start_w = 1'b0; decrypt_w = 1'b0; data_in_w = '0; key_w = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_data_out", data_out, 64'd0);
    check("reset_busy128", {63'd0, busy_w}, 64'd0);
    reset = 1'b0;

    // Known-answer encryptions, 80-bit key.
    issue(64'h0, 80'h0, 1'b0, 64'h5579c1387b228445, 32, w);
    issue(64'h0, {80{1'b1}}, 1'b0, 64'he72c46c0f5945049, 32, w);
    issue({64{1'b1}}, 80'h0, 1'b0, 64'ha112ffc72f68417b, 32, w);
    issue({64{1'b1}}, {80{1'b1}}, 1'b0, 64'h3333dcd3213210d2, 32, w);
    drain(200);

    // Known-answer encryption, 128-bit key.
    issue_w(64'h0, 128'h0, 1'b0, 64'h96db702a2e6900af, 32);
    drain(200);

`ifdef PRESENT_DECRYPT_EN
    issue(64'h5579c1387b228445, 80'h0, 1'b1, 64'h0, 63, w);
    issue(64'h3333dcd3213210d2, {80{1'b1}}, 1'b1, {64{1'b1}}, 63, w);
    issue_w(64'h96db702a2e6900af, 128'h0, 1'b1, 64'h0, 63);
    rt_pt  = 64'h834349fd8e99a23b;
    rt_key = 80'h0123456789abcdef0123;
    rt_ct  = model_enc80(rt_pt, rt_key);
    issue(rt_pt, rt_key, 1'b0, rt_ct, 32, w);
    issue(rt_ct, rt_key, 1'b1, rt_pt, 63, w);
    drain(400);
`else
    // decrypt has no effect in this build.
    issue(64'h0, 80'h0, 1'b1, 64'h5579c1387b228445, 32, w);
    drain(200);
`endif

    // Reset ten cycles into an encryption: no done, outputs cleared.
    @(negedge clk);
    start = 1'b1; decrypt = 1'b0; data_in = 64'h0123456789abcdef; key = 80'h1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_done", {63'd0, done}, 64'd0);
    check("abort_data_out", data_out, 64'd0);

    // Reset and start together: nothing is accepted.
    reset = 1'b1; start = 1'b1; data_in = '1; key = '1;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    check("reset_start_busy", {63'd0, busy}, 64'd0);
    repeat (40) @(negedge clk);

    // Fresh request after the abort.
    issue({64{1'b1}}, {80{1'b1}}, 1'b0, 64'h3333dcd3213210d2, 32, w);
    drain(200);

    // Ignored mid-operation start, then start held through done.
    issue(64'h0, 80'h0, 1'b0, 64'h5579c1387b228445, 32, wa);
    repeat (9) @(negedge clk);
    start = 1'b1; decrypt = 1'b0; data_in = '1; key = '1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    start = 1'b1; decrypt = 1'b0; data_in = '1; key = '0;
    exp_q.push_back(64'ha112ffc72f68417b);
    when_q.push_back(wa + 33);
    guard = 0;
    while (done !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    start = 1'b0;
    check("busy_back_to_back", {63'd0, busy}, 64'd1);
    drain(200);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global time bound in case a wait above misbehaves.
  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation still running at cycle %0d, expected completion", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
